crossbar_cfg_ctrl: RTL

//  Configuration front end for the N x N crossbar switch grid. It accepts a

---
 rtl/crossbar_cfg_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/crossbar_cfg_ctrl.sv
// Crossbar configuration front end: collects a (src,dst) map, rejects
// conflicting maps, drains in-flight data, then commits the ctrl matrix.
module crossbar_cfg_ctrl #(
   parameter int N = 8,
   parameter int DRAIN_CYC = 2*N-1,
   localparam int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [SW-1:0]   cfg_src,
   input  logic [SW-1:0]   cfg_dst,
   input  logic            cfg_last,
   output logic [N*N-1:0]  ctrl,
   output logic            data_hold,
   output logic            cfg_done,
   output logic            cfg_err,
   output logic [2:0]      err_code
);

   localparam int IW = $clog2(N*N);
   localparam int CW = $clog2(DRAIN_CYC);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DISCARD
   } state_t;

   state_t          state, state_nxt;
   logic [N*N-1:0]  shadow;
   logic [N-1:0]    src_used;
   logic [N-1:0]    dst_used;
   logic [2:0]      err_acc;
   logic [CW-1:0]   cnt;

   logic            accept;
   logic            loading;
   logic            src_bad;
   logic            dst_bad;
   logic [2:0]      ent_err;
   logic [2:0]      err_all;
   logic [IW-1:0]   idx;

   logic            ready_nxt;
   logic            hold_nxt;
   logic            done_nxt;
   logic            err_nxt;
   logic [2:0]      code_nxt;

   assign accept  = cfg_valid & cfg_ready;
   assign loading = accept & ((state == IDLE) | (state == LOAD));
   assign src_bad = {1'b0, cfg_src} >= (SW+1)'(N);
   assign dst_bad = {1'b0, cfg_dst} >= (SW+1)'(N);
   assign idx     = IW'(cfg_src) * IW'(N) + IW'(cfg_dst);
   assign err_all = err_acc | ent_err;

   always_comb begin
      ent_err    = '0;
      ent_err[2] = src_bad | dst_bad;
      ent_err[0] = ~src_bad & src_used[cfg_src];
      ent_err[1] = ~dst_bad & dst_used[cfg_dst];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, LOAD: begin
            if (accept) begin
               if (cfg_last)
                  state_nxt = (err_all != '0) ? IDLE : DRAIN;
               else
                  state_nxt = (err_all != '0) ? DISCARD : LOAD;
            end
         end
         DRAIN: begin
            if (cnt == '0) state_nxt = IDLE;
         end
         DISCARD: begin
            if (accept && cfg_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead so every port is a flop.
   always_comb begin
      ready_nxt = (state_nxt != DRAIN);
      hold_nxt  = (state_nxt == DRAIN);
      done_nxt  = (state == DRAIN) && (cnt == '0);
      err_nxt   = 1'b0;
      code_nxt  = '0;
      if (accept && cfg_last) begin
         if (state == DISCARD) begin
            err_nxt  = 1'b1;
            code_nxt = err_acc;
         end else if (loading && err_all != '0) begin
            err_nxt  = 1'b1;
            code_nxt = err_all;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready <= 1'b1;
         data_hold <= 1'b0;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
         err_code  <= '0;
         ctrl      <= '0;
      end else begin
         cfg_ready <= ready_nxt;
         data_hold <= hold_nxt;
         cfg_done  <= done_nxt;
         cfg_err   <= err_nxt;
         err_code  <= code_nxt;
         if (done_nxt) ctrl <= shadow;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= '0;
         src_used <= '0;
         dst_used <= '0;
         err_acc  <= '0;
         cnt      <= '0;
      end else begin
         if (done_nxt || err_nxt) begin
            shadow   <= '0;
            src_used <= '0;
            dst_used <= '0;
            err_acc  <= '0;
         end else if (loading) begin
            err_acc <= err_all;
            if (!src_bad) src_used[cfg_src] <= 1'b1;
            if (!dst_bad) dst_used[cfg_dst] <= 1'b1;
            if (!src_bad && !dst_bad) shadow[idx] <= 1'b1;
         end
         if (state_nxt == DRAIN && state != DRAIN)
            cnt <= CW'(DRAIN_CYC-1);
         else if (state == DRAIN)
            cnt <= cnt - 1'b1;
      end
   end

endmodule
